// File: rtl/ddr_pkg.sv
// Shared definitions for the chart/lane logic: FSM states, LFSR constants
// and the LFSR advance function.
package ddr_pkg;

  localparam int unsigned LFSR_W             = 16;
  localparam int unsigned MAX_NOTES_PER_BEAT = 2;

  localparam logic [LFSR_W-1:0] LFSR_POLY         = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Right-shift Galois LFSR advance.
  function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] l);
    lfsr_advance = l[0] ? ((l >> 1) ^ LFSR_POLY) : (l >> 1);
  endfunction

  // An all-zero seed would lock the LFSR, so it is swapped for the default.
  function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
    seed_fix = (s == '0) ? LFSR_DEFAULT_SEED : s;
  endfunction

endpackage

// File: rtl/lane_mask_gen.sv
// Combinational lane-mask generator: turns an LFSR value into a note mask
// with at most MAX_NOTES_PER_BEAT lanes set (lowest lane indices win).
// L[15:14] == 0 encodes a rest.
module lane_mask_gen
  import ddr_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic [LFSR_W-1:0] lfsr,
  output logic [LANES-1:0]  mask_c
);

  // Only the rest bits and the low LANES bits feed the mask.
  logic unused_mid_bits;
  assign unused_mid_bits = ^lfsr[13:LANES];

  // Keep the lowest-index set bits up to the per-beat note limit.
  always_comb begin
    int unsigned picked;
    mask_c = '0;
    picked = 0;
    if (lfsr[15:14] != 2'b00) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (lfsr[i] && (picked < MAX_NOTES_PER_BEAT)) begin
          mask_c[i] = 1'b1;
          picked    = picked + 1;
        end
      end
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Chart generator: plays STEPS beats spaced by a programmable divider and
// pulses Ren on up to two lanes per beat from a seeded LFSR.
// Build option: NOTE_SEQ_LOOP_EN makes the chart repeat forever (no DONE).
module note_sequencer
  import ddr_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned STEPS = 32,
  parameter int unsigned DIV_W = 24
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     start,
  input  logic                     pause,
  input  logic [LFSR_W-1:0]        seed,
  input  logic [DIV_W-1:0]         period,
  output logic [LANES-1:0]         Ren,
  output logic                     beat,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned STEP_W = $clog2(STEPS);

  // Elaboration-time parameter sanity.
  if (LANES < 2 || LANES > 8) begin : g_bad_lanes
    $error("note_sequencer: LANES must be 2..8");
  end
  if (STEPS < 2) begin : g_bad_steps
    $error("note_sequencer: STEPS must be >= 2");
  end

  seq_state_t          state, state_n;
  logic [DIV_W-1:0]    period_q, period_n;
  logic [DIV_W-1:0]    div, div_n;
  logic [LFSR_W-1:0]   lfsr, lfsr_n;
  logic [STEP_W-1:0]   step_n;
  logic [LANES-1:0]    ren_n;
  logic                beat_n;
  logic                busy_n;
  logic                done_n;
  // Set by the final tick so the last Ren pulse completes before DONE.
  logic                fin_pend, fin_n;
  logic [LANES-1:0]    mask_c;

  lane_mask_gen #(
    .LANES (LANES)
  ) u_mask (
    .lfsr   (lfsr),
    .mask_c (mask_c)
  );

  // State, divider, LFSR and output registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      period_q <= '0;
      div      <= '0;
      lfsr     <= LFSR_DEFAULT_SEED;
      step_idx <= '0;
      Ren      <= '0;
      beat     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fin_pend <= 1'b0;
    end else begin
      state    <= state_n;
      period_q <= period_n;
      div      <= div_n;
      lfsr     <= lfsr_n;
      step_idx <= step_n;
      Ren      <= ren_n;
      beat     <= beat_n;
      busy     <= busy_n;
      done     <= done_n;
      fin_pend <= fin_n;
    end
  end

  // Next-state, beat tick and next-output logic.
  always_comb begin
    state_n  = state;
    period_n = period_q;
    div_n    = div;
    lfsr_n   = lfsr;
    step_n   = step_idx;
    fin_n    = fin_pend;
    ren_n    = '0;
    beat_n   = 1'b0;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n  = PLAY;
          period_n = period;
          div_n    = period;
          lfsr_n   = seed_fix(seed);
          step_n   = '0;
          fin_n    = 1'b0;
        end
      end
      PLAY: begin
        if (fin_pend) begin
          state_n = DONE;
          fin_n   = 1'b0;
        end else if (!pause) begin
          if (div == '0) begin
            ren_n  = mask_c;
            beat_n = 1'b1;
            lfsr_n = lfsr_advance(lfsr);
            div_n  = period_q;
            if (step_idx == STEP_W'(STEPS - 1)) begin
              step_n = '0;
`ifdef NOTE_SEQ_LOOP_EN
              fin_n  = 1'b0;
`else
              fin_n  = 1'b1;
`endif
            end else begin
              step_n = step_idx + STEP_W'(1);
            end
          end else begin
            div_n = div - DIV_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == PLAY);
    done_n = (state_n == DONE);
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a beat-level reference model checked every cycle,
// plus directed scenarios with hand-derived literal expectations.
module tb_note_sequencer;

  localparam int unsigned LANES  = 4;
  localparam int unsigned STEPS  = 4;
  localparam int unsigned DIV_W  = 24;
  localparam int unsigned STEP_W = $clog2(STEPS);

  logic               clk    = 1'b0;
  logic               rst    = 1'b1;
  logic               start  = 1'b0;
  logic               pause  = 1'b0;
  logic [15:0]        seed   = '0;
  logic [DIV_W-1:0]   period = '0;
  logic [LANES-1:0]   Ren;
  logic               beat;
  logic [STEP_W-1:0]  step_idx;
  logic               busy;
  logic               done;

  int checks = 0;
  int errors = 0;

  note_sequencer #(
    .LANES (LANES),
    .STEPS (STEPS),
    .DIV_W (DIV_W)
  ) dut (
    .Clock    (clk),
    .Reset    (rst),
    .start    (start),
    .pause    (pause),
    .seed     (seed),
    .period   (period),
    .Ren      (Ren),
    .beat     (beat),
    .step_idx (step_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  task automatic kick(input logic [15:0] s, input logic [DIV_W-1:0] p);
    seed   = s;
    period = p;
    start  = 1'b1;
    cyc(1);
    start  = 1'b0;
  endtask

  // Reference rules: lanes set among the low LANES bits, lowest two kept; top bits 00 = rest.
  function automatic logic [LANES-1:0] model_mask(input logic [15:0] l);
    int idx[$];
    logic [LANES-1:0] m;
    m = '0;
    if (l[15:14] == 2'b00) return '0;
    for (int i = 0; i < int'(LANES); i++) if (l[i]) idx.push_back(i);
    for (int j = 0; j < idx.size() && j < 2; j++) m[idx[j]] = 1'b1;
    return m;
  endfunction

  function automatic logic [15:0] model_next(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Model: counts unpaused playing cycles; a beat lands on every (period+1)th.
  bit               m_play = 0;
  bit               m_fin  = 0;
  int               m_k    = 0;
  int               m_per  = 0;
  int               m_step = 0;
  logic [15:0]      m_l    = 16'hACE1;
  logic [LANES-1:0] exp_ren  = '0;
  logic             exp_beat = 1'b0;
  logic             exp_busy = 1'b0;
  logic             exp_done = 1'b0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_play = 0; m_fin = 0; m_k = 0; m_step = 0; m_l = 16'hACE1;
      exp_ren = '0; exp_beat = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
    end else begin
      exp_ren  = '0;
      exp_beat = 1'b0;
      if (!m_play) begin
        if (start) begin
          m_play = 1; m_fin = 0; m_k = 0; m_step = 0;
          m_per  = int'(period);
          m_l    = (seed == 16'h0000) ? 16'hACE1 : seed;
          exp_busy = 1'b1; exp_done = 1'b0;
        end
      end else if (m_fin) begin
        m_play = 0; m_fin = 0;
        exp_busy = 1'b0; exp_done = 1'b1;
      end else if (!pause) begin
        m_k++;
        if (m_k == m_per + 1) begin
          m_k      = 0;
          exp_ren  = model_mask(m_l);
          exp_beat = 1'b1;
          m_l      = model_next(m_l);
          m_step   = (m_step + 1) % STEPS;
`ifndef NOTE_SEQ_LOOP_EN
          if (m_step == 0) m_fin = 1;
`endif
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("ren",  32'(Ren),      32'(exp_ren));
    chk("beat", 32'(beat),     32'(exp_beat));
    chk("step", 32'(step_idx), 32'(m_step));
    chk("busy", 32'(busy),     32'(exp_busy));
    chk("done", 32'(done),     32'(exp_done));
  end

  initial begin
    int nb;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk("rst_ren",  32'(Ren),      32'h0);
    chk("rst_busy", 32'(busy),     32'h0);
    chk("rst_done", 32'(done),     32'h0);
    chk("rst_step", 32'(step_idx), 32'h0);

    // Seed 0xFFFF, period 3: beats every 4 cycles, mask 0011; start in PLAY ignored.
    kick(16'hFFFF, 24'd3);
    chk("s1_busy", 32'(busy), 32'h1);
    nb = 0;
    for (int i = 1; i <= 17; i++) begin
      cyc(1);
      if (beat) nb++;
      if (i == 4) begin
        chk("s1_ren1",  32'(Ren),      32'h3);
        chk("s1_beat1", 32'(beat),     32'h1);
        chk("s1_step1", 32'(step_idx), 32'h1);
      end
      if (i == 8) begin
        chk("s1_ren2",  32'(Ren),      32'h3);
        chk("s1_beat2", 32'(beat),     32'h1);
        chk("s1_step2", 32'(step_idx), 32'h2);
      end
      if (i == 10) begin
        seed = 16'h0001; period = 24'd0; start = 1'b1;
      end
      if (i == 11) start = 1'b0;
      if (i == 12) begin
        chk("s1_beat3", 32'(beat),     32'h1);
        chk("s1_ren3",  32'(Ren),      32'h3);
        chk("s1_step3", 32'(step_idx), 32'h3);
      end
    end
    chk("s1_nbeats", 32'(nb), 32'd4);
`ifdef NOTE_SEQ_LOOP_EN
    chk("s1_busy_end", 32'(busy), 32'h1);
    chk("s1_done_end", 32'(done), 32'h0);
    pulse_reset();
`else
    chk("s1_done_end", 32'(done), 32'h1);
    chk("s1_busy_end", 32'(busy), 32'h0);
`endif

    // Seed 0x0001, period 0: back-to-back rest beats; restart from DONE clears step.
    kick(16'h0001, 24'd0);
    chk("s2_step0", 32'(step_idx), 32'h0);
    chk("s2_busy",  32'(busy),     32'h1);
    cyc(1);
    chk("s2_ren1",  32'(Ren),      32'h0);
    chk("s2_beat1", 32'(beat),     32'h1);
    chk("s2_step1", 32'(step_idx), 32'h1);
    cyc(1);
    chk("s2_ren2",  32'(Ren),      32'h0);
    chk("s2_beat2", 32'(beat),     32'h1);
    chk("s2_step2", 32'(step_idx), 32'h2);
    cyc(3);
`ifdef NOTE_SEQ_LOOP_EN
    chk("s2_busy_end", 32'(busy), 32'h1);
    pulse_reset();
`else
    chk("s2_done_end", 32'(done), 32'h1);
`endif

    // Pause for 10 cycles covering a would-be tick.
    kick(16'hFFFF, 24'd2);
    nb = 0;
    for (int i = 1; i <= 19; i++) begin
      cyc(1);
      if (i >= 6 && i <= 15 && (beat || Ren != '0)) nb++;
      if (i == 3) chk("s3_ren_pre", 32'(Ren), 32'h3);
      if (i == 5) pause = 1'b1;
      if (i == 15) pause = 1'b0;
      if (i == 16) begin
        chk("s3_beat_resume", 32'(beat), 32'h1);
        chk("s3_ren_resume",  32'(Ren),  32'h3);
      end
      if (i == 19) begin
        chk("s3_beat_next", 32'(beat), 32'h1);
        chk("s3_ren_next",  32'(Ren),  32'h3);
      end
    end
    chk("s3_paused_out", 32'(nb), 32'd0);
    cyc(6);

    // Reset landing during a Ren pulse clears outputs at once.
    pulse_reset();
    kick(16'hFFFF, 24'd1);
    cyc(2);
    chk("s4_ren_pre", 32'(Ren), 32'h3);
    #2 rst = 1'b1;
    #1;
    chk("s4_ren_rst",  32'(Ren),      32'h0);
    chk("s4_busy_rst", 32'(busy),     32'h0);
    chk("s4_step_rst", 32'(step_idx), 32'h0);
    cyc(2);
    rst = 1'b0;
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (beat || Ren != '0 || busy) nb++;
    end
    chk("s4_quiet", 32'(nb), 32'd0);

    // Zero seed is replaced by 0xACE1, whose first mask is lane 0 only.
    kick(16'h0000, 24'd0);
    cyc(1);
    chk("s5_zero_seed", 32'(Ren), 32'h1);
    cyc(6);

`ifdef NOTE_SEQ_LOOP_EN
    // Looping chart: 12 beats, never done.
    pulse_reset();
    kick(16'hFFFF, 24'd0);
    nb = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      if (beat) nb++;
    end
    chk("s6_nbeats", 32'(nb),       32'd12);
    chk("s6_step",   32'(step_idx), 32'h0);
    chk("s6_busy",   32'(busy),     32'h1);
    chk("s6_done",   32'(done),     32'h0);
`endif

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Chart generator that drives the `Ren` note-enable input of each lane's light bank. On `start` it plays a fixed-length chart of `STEPS` beats. Beats are timed by a programmable clock divider, and lane patterns come from a seeded 16-bit LFSR. Each beat emits a one-cycle `Ren` pulse on zero to two lanes, so a note enters the bottom light of each selected bank. The block sits between the game control FSM and the per-lane banks, and shares their `Clock`.

## Interface
- `LANES`, 4: number of lane banks driven; must be 2..8
- `STEPS`, 32: beats per chart; must be ≥ 2
- `DIV_W`, 24: width of the beat-period register
- `Clock` in 1: system clock, rising edge
- `Reset` in 1: asynchronous, active-high; clears all state
- `start` in 1: begin a chart; sampled only in IDLE or DONE
- `pause` in 1: while high, freeze the divider and step counter, and hold `Ren` at 0
- `seed` in 16: LFSR seed, captured on an accepted `start`
- `period` in DIV_W: beat spacing minus 1 in Clock cycles, captured on an accepted `start`
- `Ren` out LANES: note-enable pulses, one bit per lane
- `beat` out 1: one-cycle strobe on every beat tick, including rests
- `step_idx` out $clog2(STEPS): index of the next beat to play
- `busy` out 1: high in PLAY
- `done` out 1: high in DONE

## Operation
- States are IDLE, PLAY and DONE. `Reset` forces IDLE.
- IDLE → PLAY on `start`. On that edge, capture `period`, load the LFSR with `seed` (0x0000 is replaced by 0xACE1), clear `step_idx`, and load the divider with `period`.
- In PLAY with `pause` low, the divider decrements each cycle. When it is 0, a beat tick occurs and the divider reloads with `period`. With `period` = 0, every cycle is a tick.
- On each tick:
  - Derive the mask from the current LFSR value L.
  - If L[15:14] = 2'b00, the mask is 0 (rest).
  - Otherwise the mask is L[LANES-1:0]. If more than two bits are set, keep only the two lowest-index set bits.
  - Register the mask onto `Ren` for exactly the next cycle. Pulse `beat`.
  - Advance the LFSR as a right-shift Galois with mask 0xB400 (when L[0] = 1: L = (L >> 1) ^ 0xB400, else L >> 1).
  - Increment `step_idx`.
- After the tick for step STEPS-1, go to DONE.
- DONE → PLAY on `start`, with the same capture as from IDLE.
- `start` in PLAY is ignored.
- `pause` asserted in the same cycle as a would-be tick suppresses that tick. The divider holds at 0 and the tick fires on the first cycle after `pause` falls.

## Timing
- Reset values: `Ren` = 0, `beat` = 0, `step_idx` = 0, `busy` = 0, `done` = 0; LFSR = 0xACE1; divider = 0.
- With `start` sampled at edge 0, `busy` is high after edge 0.
- The first tick is evaluated at edge `period`+1. `Ren` and `beat` are high during the cycle after that edge.
- Successive `Ren` pulses are `period`+1 cycles apart.
- `Ren` is never high for two consecutive cycles unless `period` = 0.
- `done` rises on the edge after the final tick's `Ren` pulse ends, so the last pulse is always fully delivered.
- Asynchronous `Reset` mid-PLAY clears `Ren` immediately; no partial pulse follows release.

## Configuration
- `NOTE_SEQ_LOOP_EN` defined: after step STEPS-1 the block stays in PLAY. `step_idx` wraps to 0 and the LFSR continues without reseeding. DONE is unreachable and `done` stays 0. Dropping `start` has no effect; only `Reset` stops play.
- Not defined: single-shot behaviour as described above.

## Structure
- Shared package `ddr_pkg` holds:
  - state enum `seq_state_t` (IDLE, PLAY, DONE)
  - `LFSR_POLY` = 16'hB400
  - `LFSR_DEFAULT_SEED` = 16'hACE1
  - `MAX_NOTES_PER_BEAT` = 2
- One sub-module, `lane_mask_gen`: combinational; takes L and LANES and produces the limited mask. It is reused by any future multi-bank chart logic.
- The divider, LFSR and FSM stay in `note_sequencer`.

## Test plan
- Reset, then `seed` = 0xFFFF, `period` = 3, pulse `start` → first `Ren` = 4'b0011 in the cycle after edge 4; LFSR becomes 0xCBFF; second `Ren` = 4'b0011 four cycles later; `beat` is coincident both times.
- `seed` = 0x0001, `period` = 0 → first two beats are rests (`Ren` = 0, `beat` = 1) with L = 0x0001 then 0xB400; `step_idx` counts 0, 1, 2 on consecutive cycles.
- STEPS = 4, `period` = 1 → exactly 4 `beat` pulses; `done` rises one cycle after the 4th; a `start` while `busy` has no effect; a `start` in DONE restarts with `step_idx` = 0.
- `pause` high for 10 cycles straddling a tick → no `Ren` or `beat` while paused; the tick fires on the first cycle after `pause` falls; subsequent spacing returns to `period`+1.
- `Reset` asserted mid-PLAY on the same cycle as a `Ren` pulse → `Ren`, `busy` and `step_idx` go to 0 asynchronously; no output until a new `start`.
- With `NOTE_SEQ_LOOP_EN` and STEPS = 4 → `step_idx` runs 0..3, 0; `busy` stays 1 and `done` stays 0 for 12 beats.
